// File: rtl/ps2_scan_decoder.sv
// PS/2 scancode decoder: folds E0/F0 prefix bytes into key events with a ready/valid output.
// Optional parity checking is enabled by defining PS2_PARITY_CHK_EN.
module ps2_scan_decoder #(
   parameter int unsigned TIMEOUT = 50000,
   parameter int unsigned TO_W    = 16
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [10:0] i_frame_in,
   input  logic        i_frame_valid,
   input  logic        i_ev_ready,
   output logic        o_ev_valid,
   output logic [7:0]  o_ev_code,
   output logic        o_ev_break,
   output logic        o_ev_ext,
   output logic        o_frame_err,
   output logic        o_overflow
);

   typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [TO_W-1:0]   r_cnt;
   logic [TO_W-1:0]   w_cnt_nxt;
   logic              r_ev_valid;
   logic [7:0]        r_ev_code;
   logic              r_ev_break;
   logic              r_ev_ext;
   logic              r_frame_err;
   logic              r_overflow;

   logic              w_par_ok;
   logic              w_bad;
   logic [7:0]        w_data;
   logic              w_emit;
   logic              w_brk;
   logic              w_ext;
   logic              w_err;
   logic              w_xfer;
   logic              w_valid_nxt;
   logic [7:0]        w_code_nxt;
   logic              w_break_nxt;
   logic              w_ext_nxt;
   logic              w_ovf_nxt;

   assign w_data = i_frame_in[8:1];

`ifdef PS2_PARITY_CHK_EN
   assign w_par_ok = ^i_frame_in[9:1];
`else
   logic w_unused_par;
   assign w_unused_par = i_frame_in[9];
   assign w_par_ok     = 1'b1;
`endif

   assign w_bad = i_frame_in[0] | ~i_frame_in[10] | ~w_par_ok;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_emit      = 1'b0;
      w_brk       = 1'b0;
      w_ext       = 1'b0;
      w_err       = 1'b0;
      if (i_frame_valid) begin
         w_cnt_nxt = '0;
         if (w_bad) begin
            w_err       = 1'b1;
            w_state_nxt = IDLE;
         end else begin
            case (r_state)
               IDLE: begin
                  if (w_data == 8'hE0) begin
                     w_state_nxt = EXT;
                  end else if (w_data == 8'hF0) begin
                     w_state_nxt = BRK;
                  end else if (w_data != 8'hFA && w_data != 8'hAA && w_data != 8'hEE) begin
                     w_emit = 1'b1;
                  end
               end
               EXT: begin
                  if (w_data == 8'hF0) begin
                     w_state_nxt = EXT_BRK;
                  end else if (w_data != 8'hE0) begin
                     w_emit      = 1'b1;
                     w_ext       = 1'b1;
                     w_state_nxt = IDLE;
                  end
               end
               BRK, EXT_BRK: begin
                  w_state_nxt = IDLE;
                  if (w_data == 8'hE0 || w_data == 8'hF0) begin
                     w_err = 1'b1;
                  end else begin
                     w_emit = 1'b1;
                     w_brk  = 1'b1;
                     w_ext  = (r_state == EXT_BRK);
                  end
               end
               default: w_state_nxt = IDLE;
            endcase
         end
      end else if (r_state != IDLE) begin
         // Abandon a dangling prefix once the inter-byte gap expires.
         if (r_cnt == TO_W'(TIMEOUT - 1)) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
         end else begin
            w_cnt_nxt = r_cnt + 1'b1;
         end
      end
   end

   // A held event is only replaced when it transfers in the same cycle.
   always_comb begin
      w_xfer      = r_ev_valid & i_ev_ready;
      w_valid_nxt = r_ev_valid & ~w_xfer;
      w_code_nxt  = r_ev_code;
      w_break_nxt = r_ev_break;
      w_ext_nxt   = r_ev_ext;
      w_ovf_nxt   = r_overflow;
      if (w_emit) begin
         if (!r_ev_valid || w_xfer) begin
            w_valid_nxt = 1'b1;
            w_code_nxt  = w_data;
            w_break_nxt = w_brk;
            w_ext_nxt   = w_ext;
         end else begin
            w_ovf_nxt = 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_ev_valid  <= 1'b0;
         r_ev_code   <= 8'h00;
         r_ev_break  <= 1'b0;
         r_ev_ext    <= 1'b0;
         r_frame_err <= 1'b0;
         r_overflow  <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_ev_valid  <= w_valid_nxt;
         r_ev_code   <= w_code_nxt;
         r_ev_break  <= w_break_nxt;
         r_ev_ext    <= w_ext_nxt;
         r_frame_err <= w_err;
         r_overflow  <= w_ovf_nxt;
      end
   end

   assign o_ev_valid  = r_ev_valid;
   assign o_ev_code   = r_ev_code;
   assign o_ev_break  = r_ev_break;
   assign o_ev_ext    = r_ev_ext;
   assign o_frame_err = r_frame_err;
   assign o_overflow  = r_overflow;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Scoreboard bench for ps2_scan_decoder: stimulus pushes expected events, a monitor pops them.
module tb_ps2_scan_decoder;

   localparam int unsigned TO = 20;

   logic        clk = 1'b0;
   logic        rst;
   logic [10:0] fin;
   logic        fv;
   logic        rdy;
   logic        ev_valid;
   logic [7:0]  ev_code;
   logic        ev_break;
   logic        ev_ext;
   logic        frame_err;
   logic        overflow;

   int          total   = 0;
   int          bad     = 0;
   int          exp_err = 0;
   int          obs_err = 0;
   logic [9:0]  sb[$];
   logic        stall_q = 1'b0;
   logic [9:0]  held_q  = '0;

   ps2_scan_decoder #(.TIMEOUT(TO), .TO_W(8)) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_frame_in    (fin),
      .i_frame_valid (fv),
      .i_ev_ready    (rdy),
      .o_ev_valid    (ev_valid),
      .o_ev_code     (ev_code),
      .o_ev_break    (ev_break),
      .o_ev_ext      (ev_ext),
      .o_frame_err   (frame_err),
      .o_overflow    (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   function automatic logic [10:0] mk(input logic [7:0] d);
      return {1'b1, ~^d, d, 1'b0};
   endfunction

   // Monitor: compare every transferred event against the scoreboard head.
   always @(negedge clk) begin
      if (rst) begin
         stall_q <= 1'b0;
      end else begin
         if (frame_err) obs_err++;
         if (stall_q && ev_valid) chk("hold", {ev_code, ev_break, ev_ext}, held_q);
         if (ev_valid && rdy) begin
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_event: got %0h want none", {ev_code, ev_break, ev_ext});
            end else begin
               chk("event", {ev_code, ev_break, ev_ext}, sb.pop_front());
            end
         end
         stall_q <= ev_valid && !rdy;
         held_q  <= {ev_code, ev_break, ev_ext};
      end
   end

   task automatic drive(input logic [10:0] f);
      @(posedge clk); #1;
      fin = f;
      fv  = 1'b1;
      @(posedge clk); #1;
      fv  = 1'b0;
   endtask

   task automatic send(input string nm, input logic [10:0] f, input logic ev,
                       input logic [9:0] e, input logic err);
      if (ev) sb.push_back(e);
      if (err) exp_err++;
      drive(f);
      chk({nm, "_err"}, frame_err, err);
      chk({nm, "_valid"}, ev_valid, ev);
      if (ev) begin
         @(posedge clk); #1;
         chk({nm, "_drop"}, ev_valid, 1'b0);
      end
   endtask

   task automatic pulse_rst();
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
   endtask

   initial begin
      rst = 1'b1;
      fv  = 1'b0;
      fin = '0;
      rdy = 1'b1;
      idle(2); #1;
      chk("rst_valid", ev_valid, 1'b0);
      chk("rst_code", ev_code, 8'h00);
      chk("rst_break", ev_break, 1'b0);
      chk("rst_ext", ev_ext, 1'b0);
      chk("rst_err", frame_err, 1'b0);
      chk("rst_ovf", overflow, 1'b0);
      rst = 1'b0;

      send("make1c", 11'h438, 1, {8'h1C, 1'b0, 1'b0}, 0);
      send("brk_f0", 11'h7E0, 0, '0, 0);
      send("brk1c", 11'h438, 1, {8'h1C, 1'b1, 1'b0}, 0);
      send("eb_e0", 11'h5C0, 0, '0, 0);
      send("eb_f0", 11'h7E0, 0, '0, 0);
      send("eb75", 11'h4EA, 1, {8'h75, 1'b1, 1'b1}, 0);
      send("ext_e0a", 11'h5C0, 0, '0, 0);
      send("ext_e0b", 11'h5C0, 0, '0, 0);
      send("ext75", 11'h4EA, 1, {8'h75, 1'b0, 1'b1}, 0);
      send("ack_fa", mk(8'hFA), 0, '0, 0);
      send("bat_aa", mk(8'hAA), 0, '0, 0);
      send("echo_ee", mk(8'hEE), 0, '0, 0);
      send("make32", mk(8'h32), 1, {8'h32, 1'b0, 1'b0}, 0);
      send("bad_start", 11'h439, 0, '0, 1);
      send("bad_stop", 11'h038, 0, '0, 1);
`ifdef PS2_PARITY_CHK_EN
      send("bad_par", 11'h638, 0, '0, 1);
`else
      send("bad_par", 11'h638, 1, {8'h1C, 1'b0, 1'b0}, 0);
`endif
      send("ff_f0a", 11'h7E0, 0, '0, 0);
      send("ff_f0b", 11'h7E0, 0, '0, 1);
      send("ff_after", 11'h438, 1, {8'h1C, 1'b0, 1'b0}, 0);
      send("efe_e0", 11'h5C0, 0, '0, 0);
      send("efe_f0", 11'h7E0, 0, '0, 0);
      send("efe_e0b", 11'h5C0, 0, '0, 1);
      send("xb_e0", 11'h5C0, 0, '0, 0);
      send("xb_bad", 11'h439, 0, '0, 1);
      send("xb_after", 11'h438, 1, {8'h1C, 1'b0, 1'b0}, 0);

      // Frame landing exactly in the timeout cycle still sees the prefix.
      send("tw_e0", 11'h5C0, 0, '0, 0);
      idle(TO - 2);
      send("tw_1c", 11'h438, 1, {8'h1C, 1'b0, 1'b1}, 0);
      send("to_e0", 11'h5C0, 0, '0, 0);
      idle(TO - 1);
      send("to_1c", 11'h438, 1, {8'h1C, 1'b0, 1'b0}, 0);

      send("rm_f0", 11'h7E0, 0, '0, 0);
      pulse_rst();
      send("rm_1c", 11'h438, 1, {8'h1C, 1'b0, 1'b0}, 0);

      // Held event with no consumer: second event is dropped.
      pulse_rst();
      rdy = 1'b0;
      sb.push_back({8'h1C, 1'b0, 1'b0});
      drive(11'h438);
      chk("ovA_valid", ev_valid, 1'b1);
      chk("ovA_ovf0", overflow, 1'b0);
      drive(mk(8'h32));
      chk("ovA_code", ev_code, 8'h1C);
      chk("ovA_ovf", overflow, 1'b1);
      @(posedge clk); #1;
      rdy = 1'b1;
      @(posedge clk); #1;
      chk("ovA_sticky", overflow, 1'b1);
      chk("ovA_empty", ev_valid, 1'b0);

      // New event completing on the transfer cycle replaces the old one.
      pulse_rst();
      chk("ovB_rst", overflow, 1'b0);
      rdy = 1'b0;
      sb.push_back({8'h1C, 1'b0, 1'b0});
      drive(11'h438);
      sb.push_back({8'h32, 1'b0, 1'b0});
      @(posedge clk); #1;
      fin = mk(8'h32);
      fv  = 1'b1;
      rdy = 1'b1;
      @(posedge clk); #1;
      fv  = 1'b0;
      chk("ovB_valid", ev_valid, 1'b1);
      chk("ovB_code", ev_code, 8'h32);
      chk("ovB_ovf", overflow, 1'b0);
      @(posedge clk); #1;
      chk("ovB_drop", ev_valid, 1'b0);

      idle(4);
      chk("sb_empty", sb.size(), 0);
      chk("err_count", obs_err, exp_err);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ps2_scan_decoder.md
PS2_SCAN_DECODER -- requirements
Module: ps2_scan_decoder

Interface
REQ-001 SHALL have parameter TIMEOUT, default 50000, meaning cycles allowed between prefix byte and following byte (1 ms at 50 MHz).
REQ-002 SHALL have parameter TO_W, default 16, meaning width of the timeout counter; TIMEOUT SHALL fit in TO_W bits.
REQ-003 SHALL run on one clock and use a synchronous, active-high reset: clk input 1, rising-edge system clock.
REQ-004 SHALL have rst input 1: synchronous, active-high reset.
REQ-005 SHALL have frame_in input 11: received PS/2 frame; bit0 start, bits[8:1] data LSB-first, bit9 parity, bit10 stop.
REQ-006 SHALL have frame_valid input 1: one-cycle strobe; frame_in is valid in that cycle.
REQ-007 SHALL have ev_valid output 1: key event available.
REQ-008 SHALL have ev_ready input 1: consumer accepts event.
REQ-009 SHALL have ev_code output 8: scancode byte.
REQ-010 SHALL have ev_break output 1: 1 = key release, 0 = key press.
REQ-011 SHALL have ev_ext output 1: 1 = E0-extended key.
REQ-012 SHALL have frame_err output 1: one-cycle pulse on a rejected frame.
REQ-013 SHALL have overflow output 1: sticky flag set when an event is lost.

Function
REQ-014 SHALL accept a frame on the rising clk edge where frame_valid=1; frame_valid=0 cycles SHALL have no effect except the timeout count.
REQ-015 SHALL reject a frame when start!=0 or stop!=1, or when parity fails (see REQ-027).
REQ-016 On rejection, frame_err SHALL pulse high in the cycle after acceptance, the byte SHALL be discarded, and the FSM SHALL go to IDLE.
REQ-017 FSM states SHALL be IDLE, EXT, BRK and EXT_BRK.
- IDLE: E0 -> EXT; F0 -> BRK; FA/AA/EE discarded, stay IDLE; any other byte emits {code, brk=0, ext=0}.
- EXT: F0 -> EXT_BRK; E0 -> stay EXT; any other byte emits {code, 0, 1} -> IDLE.
- BRK: E0/F0 -> frame_err pulse, IDLE; any other byte emits {code, 1, 0} -> IDLE.
- EXT_BRK: E0/F0 -> frame_err pulse, IDLE; any other byte emits {code, 1, 1} -> IDLE.
REQ-018 Emission latency: ev_valid SHALL rise in the cycle after the final byte is accepted.
REQ-019 ev_code/ev_break/ev_ext SHALL hold stable while ev_valid=1 and ev_ready=0.
REQ-020 An event SHALL transfer on a cycle with ev_valid=1 and ev_ready=1; ev_valid SHALL drop the next cycle unless a new event loads.
REQ-021 If a new event completes while ev_valid=1 and ev_ready=0, the new event SHALL be dropped, the held event SHALL be kept, and overflow SHALL be set.
REQ-022 If a new event completes in the same cycle as a transfer, the new event SHALL load, ev_valid SHALL stay 1, and overflow SHALL be unchanged.
REQ-023 In EXT, BRK or EXT_BRK, the counter SHALL count cycles since the last accepted frame; at TIMEOUT-1 the FSM SHALL return to IDLE, with no event and no frame_err.
REQ-024 Counter SHALL reset to 0 on every accepted frame and SHALL hold at 0 in IDLE.
REQ-025 A frame arriving in the timeout cycle SHALL be processed in the current (non-IDLE) state, so the frame wins over the timeout.

Reset
REQ-026 While rst=1 at a clk edge, the block SHALL set: FSM=IDLE, counter=0, ev_valid=0, ev_code=8'h00, ev_break=0, ev_ext=0, frame_err=0, overflow=0; reset mid-sequence SHALL discard any pending prefix; overflow SHALL clear only on reset.

Configuration
REQ-027 Macro PS2_PARITY_CHK_EN: when defined, bits[9:1] SHALL contain an odd number of ones or the frame SHALL be rejected; when undefined, bit9 SHALL be ignored and only start/stop SHALL be checked.

Verification
REQ-028 frame 11'h438 (0x1C) -> one cycle later ev_valid=1, ev_code=1C, brk=0, ext=0.
REQ-029 11'h7E0 (F0), 11'h438 -> event {1C, brk=1, ext=0}; 11'h5C0 (E0), 11'h7E0, 11'h4EA (75) -> event {75, brk=1, ext=1}.
REQ-030 11'h439 (start=1) -> frame_err pulse, no event; 11'h638 (bad parity) -> frame_err only with PS2_PARITY_CHK_EN defined, else event 1C.
REQ-031 ev_ready=0, two make frames 1C then 32 -> ev_code stays 1C, overflow=1; with ev_ready=1 in the completion cycle -> 32 loads, overflow=0.
REQ-032 11'h5C0, then no frame for TIMEOUT cycles, then 11'h438 -> event {1C, 0, 0}; rst pulse after F0 -> next 1C is reported as a make.
